// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out: drives the shared GPU read address and shows the encrypted
// and decrypted images side by side as grayscale. The memory read latency is absorbed by a delay line.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned ENC_X0   = 32,
    parameter int unsigned DEC_X0   = 352,
    parameter int unsigned IMG_Y0   = 112,
    parameter int unsigned READ_LAT = 2,
    parameter logic [7:0]  BORDER   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  encrypted_gpu,
    input  logic [7:0]  decrypted_gpu,
    output logic [31:0] gpu_address,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int LAT = READ_LAT;

    if ((ENC_X0 < DEC_X0 + IMG_W) && (DEC_X0 < ENC_X0 + IMG_W)) begin : g_overlap_chk
        $error("vga_scanout: encrypted and decrypted windows overlap");
    end
    if (DEC_X0 + IMG_W > H_ACTIVE) begin : g_dec_fit_chk
        $error("vga_scanout: decrypted window extends past the active area");
    end

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic enc_win;
        logic dec_win;
        logic frame;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                    enc_win: 1'b0, dec_win: 1'b0, frame: 1'b0};

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h32, v32, addr_d, addr_q;
    logic          y_win;
    ctrl_t         ctrl_new, tail;
    ctrl_t         ctrl_q [0:LAT];
    ctrl_t         ctrl_d [0:LAT];
    logic [7:0]    pix_d, pix_q;
    logic          hsync_d, hsync_q, vsync_d, vsync_q, blank_d, blank_q, fs_d, fs_q;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    // Stage 1: timing decode of the counter state and the memory address.
    always_comb begin
        h32 = 32'(h_q);
        v32 = 32'(v_q);
        y_win = (v32 >= IMG_Y0) && (v32 < IMG_Y0 + IMG_H);
        ctrl_new = CTRL_IDLE;
        ctrl_new.active  = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        ctrl_new.hsync_n = !((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC));
        ctrl_new.vsync_n = !((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC));
        ctrl_new.enc_win = y_win && (h32 >= ENC_X0) && (h32 < ENC_X0 + IMG_W);
        ctrl_new.dec_win = y_win && (h32 >= DEC_X0) && (h32 < DEC_X0 + IMG_W);
        ctrl_new.frame   = (h_q == '0) && (v_q == '0);
        addr_d = '0;
        if (ctrl_new.enc_win) begin
            addr_d = (v32 - IMG_Y0) * IMG_W + (h32 - ENC_X0);
        end else if (ctrl_new.dec_win) begin
            addr_d = (v32 - IMG_Y0) * IMG_W + (h32 - DEC_X0);
        end
    end

    // Stages 2..READ_LAT+1: control rides alongside the memory read.
    always_comb begin
        ctrl_d[0] = ctrl_new;
        for (int i = 1; i <= LAT; i++) begin
            ctrl_d[i] = ctrl_q[i-1];
        end
    end

    // Output stage: memory data and the matching control slot meet here.
    always_comb begin
        tail    = ctrl_q[LAT];
        pix_d   = 8'h00;
        if (tail.enc_win) begin
            pix_d = encrypted_gpu;
        end else if (tail.dec_win) begin
            pix_d = decrypted_gpu;
        end else if (tail.active) begin
            pix_d = BORDER;
        end
        hsync_d = tail.hsync_n;
        vsync_d = tail.vsync_n;
        blank_d = tail.active;
        fs_d    = tail.frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                ctrl_q[i] <= CTRL_IDLE;
            end
            pix_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            for (int i = 0; i <= LAT; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
            pix_q   <= pix_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign gpu_address = addr_q;
    assign vga_r       = pix_q;
    assign vga_g       = pix_q;
    assign vga_b       = pix_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = clk;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced screen geometry so several full frames fit the run.
// Expected pins come from a pixel-index model of the raster; a separate monitor pops and compares.
module tb_vga_scanout;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
    localparam int IW = 16, IH = 16, E0 = 4, D0 = 36, Y0 = 8;
    localparam int LAT = 2;
    localparam int D = LAT + 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [7:0] BRD = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  encrypted_gpu, decrypted_gpu;
    logic [31:0] gpu_address;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_clk, frame_start;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .ENC_X0(E0), .DEC_X0(D0), .IMG_Y0(Y0),
        .READ_LAT(LAT), .BORDER(BRD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .encrypted_gpu(encrypted_gpu), .decrypted_gpu(decrypted_gpu),
        .gpu_address(gpu_address),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_clk(vga_clk), .frame_start(frame_start)
    );

    // Memory with READ_LAT clocks from a registered address to data on the inputs.
    logic [7:0] enc_mem [0:255];
    logic [7:0] dec_mem [0:255];
    logic [7:0] rd_a1 = '0;
    logic [7:0] rd_a2 = '0;
    always @(posedge clk) begin
        rd_a1 <= gpu_address[7:0];
        rd_a2 <= rd_a1;
    end
    assign encrypted_gpu = enc_mem[rd_a2];
    assign decrypted_gpu = dec_mem[rd_a2];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  gray;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
    } exp_t;

    exp_t sb_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.addr = '0; e.gray = '0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    // What the screen shows at raster index n (n = 0 is pixel (0,0) of a frame).
    function automatic exp_t pixel_at(input int n);
        exp_t e;
        int h, v, a;
        bit act, yw, in_enc, in_dec;
        h = n % HT;
        v = (n / HT) % VT;
        act    = (h < HA) && (v < VA);
        yw     = (v >= Y0) && (v < Y0 + IH);
        in_enc = yw && (h >= E0) && (h < E0 + IW);
        in_dec = yw && (h >= D0) && (h < D0 + IW);
        a = 0;
        if (in_enc) a = (v - Y0) * IW + (h - E0);
        if (in_dec) a = (v - Y0) * IW + (h - D0);
        e.addr  = 32'(a);
        e.gray  = !act ? 8'h00 : in_enc ? enc_mem[a[7:0]] : in_dec ? dec_mem[a[7:0]] : BRD;
        e.hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs    = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e.blank = act;
        e.fs    = (h == 0) && (v == 0);
        return e;
    endfunction

    // Stimulus side: one expectation per clock edge.
    initial begin : driver
        int cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cnt = 0;
                sb_q.push_back(idle_exp());
            end else begin
                cnt++;
                e = (cnt >= D) ? pixel_at(cnt - D) : idle_exp();
                e.addr = pixel_at(cnt - 1).addr;
                sb_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int hs_run, bl_run, last_fs, cyc;
        hs_run = 0; bl_run = 0; last_fs = -1; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("gpu_address", gpu_address, e.addr);
                chk("vga_r", 32'(vga_r), 32'(e.gray));
                chk("vga_g", 32'(vga_g), 32'(e.gray));
                chk("vga_b", 32'(vga_b), 32'(e.gray));
                chk("vga_hsync", 32'(vga_hsync), 32'(e.hs));
                chk("vga_vsync", 32'(vga_vsync), 32'(e.vs));
                chk("vga_blank_n", 32'(vga_blank_n), 32'(e.blank));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                chk("vga_sync_n", 32'(vga_sync_n), 32'd0);
                chk("vga_clk", 32'(vga_clk), 32'(clk));
            end
            if (!rst_n) begin
                hs_run = 0; bl_run = 0; last_fs = -1;
            end else begin
                if (!vga_hsync) hs_run++;
                else if (hs_run > 0) begin
                    chk("hsync_width", 32'(hs_run), 32'(HS));
                    hs_run = 0;
                end
                if (vga_blank_n) bl_run++;
                else if (bl_run > 0) begin
                    chk("blank_width", 32'(bl_run), 32'(HA));
                    bl_run = 0;
                end
                if (frame_start) begin
                    if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                    last_fs = cyc;
                end
            end
        end
    end

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_addr"}, gpu_address, 32'd0);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
        chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    task automatic release_and_time_frame(input string tag);
        int k;
        @(negedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (frame_start) begin
                k = i;
                break;
            end
        end
        chk({tag, "_fs_latency"}, 32'(k), 32'(D));
    endtask

    initial begin : main
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            enc_mem[i] = 8'(i);
            dec_mem[i] = ~8'(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk_reset_pins("por");
        release_and_time_frame("por");
        repeat (2 * FRAME + 100) @(posedge clk);

        // Mid-frame reset at a random raster position, new random image contents.
        repeat ($urandom_range(FRAME - 1, 0)) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_pins("midrst");
        for (int i = 0; i < 256; i++) begin
            enc_mem[i] = 8'($urandom);
            dec_mem[i] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        release_and_time_frame("midrst");
        repeat (FRAME + 2 * HT + 50) @(posedge clk);

        @(negedge clk);
        #1 chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
